// File: rtl/rca_pkg.sv
// ============================================================================
// rca_pkg : state encoding and derived-size helpers for the sequential adder
// Revision: 1.0
// ============================================================================
`default_nettype none

package rca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_RSVD = 2'd3
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index counter is never narrower than one bit, even for a single chunk.
  function automatic int calc_idxw(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rca_slice.sv
// ============================================================================
// rca_slice : combinational CHUNK-bit ripple-carry adder, also exposing the
//             carry into its top bit for signed-overflow detection
// Revision: 1.0
// ============================================================================
`default_nettype none

module rca_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co    = w_c[CHUNK];
  assign c_msb = w_c[CHUNK - 1];

endmodule

`default_nettype wire

// File: rtl/rca_seq_adder.sv
// ============================================================================
// rca_seq_adder : multi-cycle WIDTH-bit adder, CHUNK bits per clock through a
//                 single shared ripple slice, valid/ready on both sides
// Revision: 1.0
// ============================================================================
`default_nettype none

module rca_seq_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = calc_idxw(NCHUNK);
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  if (WIDTH < 2) begin : g_chk_width
    $error("rca_seq_adder: WIDTH must be >= 2");
  end
  if ((CHUNK < 1) || (CHUNK > WIDTH)) begin : g_chk_chunk
    $error("rca_seq_adder: CHUNK must be in 1..WIDTH");
  end
  if ((CHUNK >= 1) && ((WIDTH % CHUNK) != 0)) begin : g_chk_mod
    $error("rca_seq_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_s;
  logic               r_carry;
  logic               r_co;
  logic               r_ovf;
  logic [IDXW-1:0]    r_idx;

  logic [31:0]        w_base;
  logic               w_last;
  logic [CHUNK-1:0]   w_sl_a;
  logic [CHUNK-1:0]   w_sl_b;
  logic [CHUNK-1:0]   w_sl_s;
  logic               w_sl_co;
  logic               w_sl_cmsb;
  logic [WIDTH-1:0]   w_s_merged;

  // Chunk selection by shifting keeps the select free of index-width issues.
  assign w_base     = 32'(r_idx) * CHUNK;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_sl_a     = CHUNK'(r_a >> w_base);
  assign w_sl_b     = CHUNK'(r_b >> w_base);
  assign w_s_merged = (r_s & ~(CHUNK_MASK << w_base)) | (WIDTH'(w_sl_s) << w_base);

  rca_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a     (w_sl_a),
    .b     (w_sl_b),
    .ci    (r_carry),
    .s     (w_sl_s),
    .co    (w_sl_co),
    .c_msb (w_sl_cmsb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The unused encoding behaves exactly like IDLE.
  always_comb begin
    w_next_state = ST_IDLE;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_BUSY: begin
        w_next_state = w_last ? ST_DONE : ST_BUSY;
      end
      ST_DONE: begin
        out_valid    = 1'b1;
        w_next_state = out_ready ? ST_IDLE : ST_DONE;
      end
      default: begin
        in_ready     = 1'b1;
        w_next_state = in_valid ? ST_BUSY : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_BUSY: begin
          r_s     <= w_s_merged;
          r_carry <= w_sl_co;
          if (w_last) begin
            r_co  <= w_sl_co;
            r_ovf <= w_sl_cmsb ^ w_sl_co;
            r_idx <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
        end
        default: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= ci;
            r_idx   <= '0;
          end
        end
      endcase
    end
  end

  assign s   = r_s;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule

`default_nettype wire
